cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single main-memory port between I-cache and D-cache miss/writeback logic.
//  Sits below both cache controllers.
//  Accepts one transaction at a time and sequences it through issue, stall and read latency.
//  Returns a one-cycle done pulse (plus read data) to the winning requester.
//  Default priority goes to the D-cache; an I-cache starvation guard bounds fetch delay.
// PARAMETERS
//  ADDR_W        16  address width
//  DATA_W        16  data width
//  LATENCY        2  cycles from memory accept edge to valid mem_data_out (>=1)
//  STARVE_LIMIT   3  consecutive D grants won over a pending I request before I is forced to win (>=1)
// PORTS
//  clk            in   1       system clock
//  rst            in   1       asynchronous active-high reset
//  i_req          in   1       I-cache read request; held with i_addr until i_done
//  i_addr         in   ADDR_W  I-cache read address
//  i_grant        out  1       I transaction in progress
//  i_done         out  1       one-cycle pulse, i_rdata valid
//  i_rdata        out  DATA_W  read data to I-cache
//  d_req          in   1       D-cache request; held with d_wr/d_addr/d_wdata until d_done
//  d_wr           in   1       1=write, 0=read
//  d_addr         in   ADDR_W  D-cache address
//  d_wdata        in   DATA_W  D-cache write data
//  d_grant        out  1       D transaction in progress
//  d_done         out  1       one-cycle pulse; d_rdata valid on reads
//  d_rdata        out  DATA_W  read data to D-cache
//  mem_rd         out  1       memory read strobe
//  mem_wr         out  1       memory write strobe
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  DATA_W  memory write data
//  mem_stall      in   1       memory refuses this cycle's strobe (bank busy)
//  mem_rdata      in   DATA_W  memory read data
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0, owner=none. All outputs 0, including data buses.
//  States:
//   IDLE: arbitrate on i_req/d_req; winner latched (owner, wr, addr, wdata); next=ISSUE. No request -> stay.
//   ISSUE: drive mem_rd or mem_wr, mem_addr and mem_wdata from the latched values.
//    mem_stall=1 -> stay and hold all strobes/values.
//    mem_stall=0 -> accept edge; a read goes to WAIT with cnt=LATENCY-1, a write goes to DONE.
//   WAIT: strobes 0; cnt decrements each cycle. At cnt==0, capture mem_rdata and go to DONE.
//   DONE: owner's done=1 for exactly one cycle, rdata from the capture register; next=IDLE.
//  Grants: owner's grant=1 in ISSUE, WAIT and DONE; never both grants high.
//  Arbitration (IDLE only):
//   Only one requester -> it wins.
//   Both requesting:
//    starve_cnt==STARVE_LIMIT -> I wins.
//    Otherwise D wins and starve_cnt increments.
//   I wins -> starve_cnt=0. D wins while i_req=0 -> starve_cnt unchanged.
//   starve_cnt saturates at STARVE_LIMIT.
//  Latency:
//   Read, no stall: req seen in IDLE at cycle 0; ISSUE cycle 1; WAIT cycles 2..LATENCY+1; done cycle LATENCY+2.
//   Write, no stall: done cycle 2.
//   Each stalled ISSUE cycle adds one.
//  Requests are sampled only in IDLE. A requester drops req the cycle after its done; a held req re-arbitrates in IDLE.
//  rdata holds its last value after done. d_rdata is not updated on writes.
//  Requester changing addr/data mid-transaction is ignored (values latched in IDLE).
//  Async rst mid-transaction: immediate return to IDLE, strobes drop, no done pulse, the memory op is abandoned.
// TESTING
//  1. I read 0x0040, LATENCY=2, no stall -> mem_rd=1 cycle 1; i_done=1 cycle 4; i_rdata=mem word; i_grant cycles 1-4.
//  2. D write 0x1234 to 0x0200, mem_stall=1 for 3 cycles -> mem_wr/addr/wdata held cycles 1-4; d_done cycle 5.
//  3. i_req and d_req (reads) held continuously, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; no overlap.
//  4. d_req arrives one cycle after i_req, I in WAIT -> D waits; D ISSUE starts 2 cycles after i_done.
//  5. rst asserted mid-WAIT -> same cycle: grants, strobes and done=0; after release, new I read completes normally.
//  6. LATENCY=1 read -> exactly one WAIT cycle; done cycle 3; captured data matches mem_rdata of the WAIT cycle.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one main-memory port between I-cache and D-cache
//
// Purpose: accepts one cache transaction at a time (I read, D read or D write),
// sequences it through ISSUE (with memory stall), WAIT (read latency) and DONE,
// and returns a one-cycle done pulse plus read data to the requester that won.
// D-cache wins by default; a starvation counter forces I to win after
// STARVE_LIMIT consecutive D grants taken over a pending I request.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_req, i_addr                     I-cache read request (held until i_done)
//   i_grant, i_done, i_rdata          I transaction active / done pulse / read data
//   d_req, d_wr, d_addr, d_wdata      D-cache request (held until d_done)
//   d_grant, d_done, d_rdata          D transaction active / done pulse / read data
//   mem_rd, mem_wr, mem_addr, mem_wdata  memory strobes and request values
//   mem_stall                         memory refuses this cycle's strobe
//   mem_rdata                         memory read data
module cache_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t            state, state_nx;
  owner_t            owner;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic              grab_i, grab_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grab_i    = 1'b0;
    grab_d    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    i_grant   = (state != IDLE) && (owner == OWN_I);
    d_grant   = (state != IDLE) && (owner == OWN_D);
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // D wins unless I is also waiting and has been passed over STARVE_LIMIT times
          if (d_req && !(i_req && starve_cnt == STV_MAX)) grab_d = 1'b1;
          else                                             grab_i = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd    = !lat_wr;
        mem_wr    = lat_wr;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (!mem_stall) state_nx = lat_wr ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        i_done   = (owner == OWN_I);
        d_done   = (owner == OWN_D);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_NONE;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      starve_cnt <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (grab_i || grab_d) begin
        owner     <= grab_d ? OWN_D : OWN_I;
        lat_wr    <= grab_d && d_wr;
        lat_addr  <= grab_d ? d_addr : i_addr;
        lat_wdata <= grab_d ? d_wdata : '0;
        // Only a D win over a pending I request counts toward starvation
        if (grab_i)
          starve_cnt <= '0;
        else if (i_req && starve_cnt != STV_MAX)
          starve_cnt <= starve_cnt + STV_W'(1);
      end
      if (state == ISSUE && !mem_stall && !lat_wr)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      // Read data lands directly in the owner's output register, which then holds
      if (state == WAIT && cnt == '0) begin
        if (owner == OWN_D) d_rdata <= mem_rdata;
        else                i_rdata <= mem_rdata;
      end
      if (state == DONE) owner <= OWN_NONE;
    end
  end

endmodule
